// File: rtl/onehot_grant_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// onehot_grant_sequencer_pkg : FSM encoding and index-width helper (rev 1.0)
// ============================================================================
package onehot_grant_sequencer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_grant_sequencer_onehot_to_binary.sv
`default_nettype none
// ============================================================================
// onehot_to_binary : OR-reduction decode of a one-hot vector to its index (rev 1.0)
// ============================================================================
module onehot_to_binary
  import onehot_grant_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]            onehot,
  output logic [idx_width(WIDTH)-1:0] idx
);

  localparam int IDX_W = idx_width(WIDTH);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/onehot_grant_sequencer.sv
`default_nettype none
// ============================================================================
// onehot_grant_sequencer : packet-level MSB-priority arbiter with watchdog (rev 1.0)
// ============================================================================
module onehot_grant_sequencer
  import onehot_grant_sequencer_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 0,
  parameter int IDX_W   = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  input  logic             sel_valid,
  input  logic             sel_ready,
  input  logic             sel_last,
  output logic [WIDTH-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout_err
);

  localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [WIDTH-1:0] req_rev, req_rev_low, req_msb;
  logic             beat;

  // Highest-index winner: reverse, keep the lowest set bit, reverse back.
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign req_rev[i] = req[WIDTH-1-i];
    assign req_msb[i] = req_rev_low[WIDTH-1-i];
  end
  assign req_rev_low = req_rev & (~req_rev + WIDTH'(1));

  onehot_to_binary #(.WIDTH(WIDTH)) u_dec (
    .onehot (grant_d),
    .idx    (grant_idx_d)
  );

  assign beat = sel_valid & sel_ready & grant_valid_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    timeout_err_d = 1'b0;
    wdog_d        = wdog_q;
    case (state_q)
      ST_IDLE: begin
        wdog_d        = '0;
        grant_d       = req_msb;
        grant_valid_d = |req;
        if (|req) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (beat && sel_last) begin
          state_d       = ST_IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
        end else if (beat) begin
          wdog_d = '0;
        end else if (TIMEOUT > 0) begin
          // Counter would reach TIMEOUT on this stalled cycle: revoke now.
          if (wdog_q == WDOG_LAST) begin
            state_d       = ST_IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            timeout_err_d = 1'b1;
          end else if (wdog_q != '1) begin
            wdog_d = wdog_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_err_q <= timeout_err_d;
      wdog_q        <= wdog_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_grant_sequencer.sv
`default_nettype none
// ============================================================================
// tb_onehot_grant_sequencer : directed + random bench against a behavioural model (rev 1.0)
// ============================================================================
module tb_onehot_grant_sequencer;

  localparam int TO_A = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req = '0;
  logic        req_b = 1'b0;
  logic        sel_valid = 1'b0, sel_ready = 1'b0, sel_last = 1'b0;

  logic [15:0] grant_a;
  logic [3:0]  idx_a, idx_ref_a;
  logic        valid_a, err_a;
  logic        grant_b, idx_b, valid_b, err_b;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: owner = granted requester index, -1 when idle.
  typedef struct packed {
    int owner;
    int stall;
    bit err;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  onehot_grant_sequencer #(.WIDTH(16), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(reset), .req(req),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_last(sel_last),
    .grant(grant_a), .grant_idx(idx_a), .grant_valid(valid_a), .timeout_err(err_a)
  );

  onehot_grant_sequencer #(.WIDTH(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_last(sel_last),
    .grant(grant_b), .grant_idx(idx_b), .grant_valid(valid_b), .timeout_err(err_b)
  );

  onehot_to_binary #(.WIDTH(16)) u_ref (.onehot(grant_a), .idx(idx_ref_a));

  function automatic mdl_t mdl_idle();
    mdl_t s;
    s.owner = -1;
    s.stall = 0;
    s.err   = 1'b0;
    return s;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input logic [15:0] r,
                                    input logic v, input logic rd, input logic l,
                                    input int to);
    mdl_t n;
    n = s;
    n.err = 1'b0;
    if (s.owner < 0) begin
      for (int i = 0; i < 16; i++) if (r[i]) n.owner = i;
      n.stall = 0;
    end else if (v && rd && l) begin
      n.owner = -1;
    end else if (v && rd) begin
      n.stall = 0;
    end else if (to > 0) begin
      n.stall = s.stall + 1;
      if (n.stall >= to) begin
        n.owner = -1;
        n.err   = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [15:0] exp_grant(input mdl_t s);
    return (s.owner >= 0) ? (16'd1 << s.owner) : 16'd0;
  endfunction

  function automatic logic [31:0] exp_idx(input mdl_t s);
    return (s.owner >= 0) ? 32'(s.owner) : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= mdl_idle();
      mb <= mdl_idle();
    end else begin
      ma <= mdl_step(ma, req, sel_valid, sel_ready, sel_last, TO_A);
      mb <= mdl_step(mb, {15'd0, req_b}, sel_valid, sel_ready, sel_last, 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("grant_a", 32'(grant_a), 32'(exp_grant(ma)));
      check("idx_a",   32'(idx_a),   exp_idx(ma));
      check("valid_a", 32'(valid_a), 32'(ma.owner >= 0));
      check("err_a",   32'(err_a),   32'(ma.err));
      check("onehot0_a",   32'($onehot0(grant_a)), 32'd1);
      check("idx_match_a", 32'(idx_a), 32'(idx_ref_a));
      check("grant_b", 32'(grant_b), 32'(exp_grant(mb)));
      check("idx_b",   32'(idx_b),   32'd0);
      check("valid_b", 32'(valid_b), 32'(mb.owner >= 0));
      check("err_b",   32'(err_b),   32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant_a), 32'd0);
    check("rst_idx",   32'(idx_a),   32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_err",   32'(err_a),   32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Idle for 20 cycles
    repeat (20) @(negedge clk);
    check("idle_grant", 32'(grant_a), 32'd0);
    check("idle_valid", 32'(valid_a), 32'd0);

    // req=5 -> bit 2 wins one cycle later
    req = 16'h0005;
    @(negedge clk);
    check("t2_grant", 32'(grant_a), 32'h0004);
    check("t2_idx",   32'(idx_a),   32'd2);
    check("t2_valid", 32'(valid_a), 32'd1);

    // Request changes mid-packet are ignored; one bubble after release
    req = 16'h8000;
    repeat (2) @(negedge clk);
    check("t3_hold", 32'(grant_a), 32'h0004);
    sel_valid = 1'b1; sel_ready = 1'b1; sel_last = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0; sel_last = 1'b0;
    check("t3_bubble_grant", 32'(grant_a), 32'd0);
    check("t3_bubble_valid", 32'(valid_a), 32'd0);
    @(negedge clk);
    check("t3_regrant", 32'(grant_a), 32'h8000);
    check("t3_regrant_idx", 32'(idx_a), 32'd15);

    // Watchdog: eight stalled cycles revoke the grant
    repeat (7) @(negedge clk);
    check("t4_pre_grant", 32'(grant_a), 32'h8000);
    check("t4_pre_err",   32'(err_a),   32'd0);
    @(negedge clk);
    check("t4_to_grant", 32'(grant_a), 32'd0);
    check("t4_to_err",   32'(err_a),   32'd1);
    @(negedge clk);
    check("t4_err_pulse", 32'(err_a), 32'd0);
    check("t4_regrant",   32'(grant_a), 32'h8000);
    // A beat on the seventh stalled cycle restarts the count
    repeat (6) @(negedge clk);
    sel_valid = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("t4_beat_grant", 32'(grant_a), 32'h8000);
    check("t4_beat_err",   32'(err_a),   32'd0);
    sel_valid = 1'b1; sel_last = 1'b1; req = '0;
    @(negedge clk);
    sel_valid = 1'b0; sel_last = 1'b0;
    check("t4_release", 32'(grant_a), 32'd0);
    @(negedge clk);

    // Asynchronous reset mid-packet
    req = 16'h0004;
    @(negedge clk);
    check("t5_grant", 32'(grant_a), 32'h0004);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_grant", 32'(grant_a), 32'd0);
    check("t5_rst_idx",   32'(idx_a),   32'd0);
    check("t5_rst_valid", 32'(valid_a), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_after_grant", 32'(grant_a), 32'h0004);
    check("t5_after_idx",   32'(idx_a),   32'd2);
    sel_valid = 1'b1; sel_last = 1'b1; req = '0;
    @(negedge clk);
    sel_valid = 1'b0; sel_last = 1'b0;

    // Single-requester instance
    req_b = 1'b1;
    @(negedge clk);
    check("t6_grant_b", 32'(grant_b), 32'd1);
    check("t6_idx_b",   32'(idx_b),   32'd0);
    sel_valid = 1'b1; sel_last = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0; sel_last = 1'b0; req_b = 1'b0;
    check("t6_release_b", 32'(grant_b), 32'd0);

    // Random soak; alternating phases of sparse and dense valid
    for (int c = 0; c < 10000; c++) begin
      logic [15:0] rv;
      rv = 16'($urandom);
      case ($urandom_range(3))
        0:       req = '0;
        1:       req = 16'd1 << $urandom_range(15);
        default: req = rv;
      endcase
      req_b     = 1'($urandom_range(1));
      sel_valid = ((c / 500) % 2 == 1) ? ($urandom_range(9) == 0) : 1'($urandom_range(1));
      sel_ready = ($urandom_range(3) != 0);
      sel_last  = ($urandom_range(3) == 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
